nibble_serial_addsub: RTL
=========================

# nibble_serial_addsub

Multi-cycle N-bit adder/subtractor that sits directly upstream of, and drives, one 4-bit ripple adder slice (A, B, Ci -> S, Co).
- It latches wide operands on a start strobe and feeds them to the slice one nibble per clock, LSB nibble first.
- It registers the slice's carry between nibbles and assembles the full result word.
- It trades latency for area when the datapath needs 16/32-bit arithmetic but only one 4-bit slice is budgeted.

## Interface
- NIBBLES, default 4: number of 4-bit nibbles; operand width W = 4*NIBBLES. Legal range 2..8.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- sub  in  1  0 = A+B, 1 = A-B; sampled with start.
- A  in  W  operand A; sampled with start.
- B  in  W  operand B; sampled with start.
- S  out  W  result word; valid while done=1, held until next accepted start.
- Co  out  1  carry out of MSB (sub: 1 = no borrow, i.e. A >= B unsigned); valid with done, held.
- V  out  1  signed two's-complement overflow; valid with done, held.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse marking result valid.

## Operation
- Internally instantiates one 4-bit ripple adder slice; all arithmetic passes through it.
- Registers:
  - a_r and bx_r (W bits): bx_r = sub ? ~B : B.
  - carry register c_r.
  - nibble counter cnt, ceil(log2(NIBBLES)) bits.
  - sign latch of a_r[W-1] and bx_r[W-1] (or read from a_r/bx_r).
- FSM states:
  - IDLE:
    - start=1 -> load a_r=A, bx_r=(sub?~B:B), c_r=sub, cnt=0, S=0; go RUN.
    - start=0 -> stay IDLE.
  - RUN: slice inputs are a_r[4*cnt+3:4*cnt], bx_r[4*cnt+3:4*cnt], c_r. Each edge:
    - S[4*cnt+3:4*cnt] <= slice S.
    - c_r <= slice Co.
    - cnt <= cnt+1.
    - When cnt == NIBBLES-1: Co <= slice Co, V <= (a_r[W-1] == bx_r[W-1]) & (slice S[3] != a_r[W-1]), done <= 1; go DONE.
  - DONE: done=1 for this cycle only. Next edge -> IDLE, done <= 0.
- start while busy (RUN or DONE) is ignored; A/B/sub changes while busy have no effect.
- Arithmetic is modulo 2^W; subtraction is A + ~B + 1. No saturation.
- S nibbles above cnt read 0 during RUN; consumers must qualify S with done.
- Reset (asynchronous, any state, including mid-operation):
  - Sets S=0, Co=0, V=0, done=0, busy=0, state=IDLE, cnt=0, c_r=0.
  - An in-flight operation is abandoned with no done pulse.
  - The first start after reset deasserts is handled normally.

## Timing
- Edge E0 samples start=1 in IDLE.
- busy=1 from after E0 through the DONE cycle.
- Nibble k is written at edge E0+k+1, for k = 0..NIBBLES-1.
- done=1 in the cycle after edge E0+NIBBLES; S, Co and V are final in that same cycle.
- Edge E0+NIBBLES+1 returns to IDLE: busy=0, done=0.
- The earliest next start is sampled at E0+NIBBLES+2. Throughput is one operation per NIBBLES+2 cycles.
- For NIBBLES=4: latency 4 edges from sample to done, throughput one operation per 6 cycles.
- Critical path is one 4-bit ripple chain plus the operand nibble mux; no combinational path from start/A/B to any output.

## Test plan
- Reset and idle:
  - Assert rst asynchronously between edges mid-RUN (NIBBLES=4, after 2 nibbles) -> S=0, Co=0, V=0, busy=0, done=0 immediately, with no done pulse afterward.
  - Release reset, then issue a new start -> correct result.
- Add, no carry (NIBBLES=4): A=0x1234, B=0x4321, sub=0 -> S=0x5555, Co=0, V=0.
  - done pulses exactly once, 4 edges after the sampling edge.
  - busy is high for 5 cycles.
- Carry ripple across all nibbles: A=0xFFFF, B=0x0001, sub=0 -> S=0x0000, Co=1, V=0.
- Subtract and overflow:
  - A=0x0005, B=0x0007, sub=1 -> S=0xFFFE, Co=0 (borrow), V=0.
  - A=0x8000, B=0x0001, sub=1 -> S=0x7FFF, Co=1, V=1.
  - A=0x7FFF, B=0x0001, sub=0 -> S=0x8000, V=1.
- Handshake:
  - Hold start=1 continuously with changing A/B -> operands are sampled only in IDLE, and each result matches the operands present at its sampling edge.
  - Starts during busy are ignored.
  - Back-to-back operations are spaced 6 cycles apart.
- Parameter sweep: NIBBLES=2 and 8 with 1000 random A/B/sub each -> S, Co and V match a reference model, done latency equals NIBBLES edges, and S holds stable between operations.

Source files
------------

// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: a W-bit adder/subtractor (W = 4*NIBBLES) built from
// one 4-bit ripple slice. The slice is used once per clock, least significant
// nibble first, and the carry is kept in a register between nibbles.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous reset, active high
//   start  in   1  operation request, sampled only while idle
//   sub    in   1  0 = A+B, 1 = A-B, sampled with start
//   A, B   in   W  operands, sampled with start
//   S      out  W  result word, valid while done, held until the next start
//   Co     out  1  carry out of the MSB (when subtracting, 1 = no borrow)
//   V      out  1  signed two's-complement overflow
//   busy   out  1  operation in progress (RUN or DONE)
//   done   out  1  one-cycle pulse, result valid

// 4-bit ripple-carry adder slice.
module ripple_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  // Full-adder chain, bit 0 first.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co = c[4];

endmodule

module nibble_serial_addsub #(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] S,
  output logic         Co,
  output logic         V,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  // Catch an out-of-range parameter at elaboration.
  if (NIBBLES < 2 || NIBBLES > 8) begin : g_bad_nibbles
    $error("nibble_serial_addsub: NIBBLES must be in 2..8");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_n;

  logic [W-1:0]    a_r;
  logic [W-1:0]    bx_r;
  logic            c_r;
  logic [CW-1:0]   cnt;

  logic [W-1:0]    a_n;
  logic [W-1:0]    bx_n;
  logic            c_n;
  logic [CW-1:0]   cnt_n;
  logic [W-1:0]    s_n;
  logic            co_n;
  logic            v_n;
  logic            busy_n;
  logic            done_n;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      slice_s;
  logic            slice_co;

  // Operand nibble select; a compare-per-nibble mux avoids an out-of-range
  // part-select for NIBBLES that are not a power of two.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_r[4*i +: 4];
        b_nib = bx_r[4*i +: 4];
      end
    end
  end

  ripple_adder4 u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (c_r),
    .s  (slice_s),
    .co (slice_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (start) state_n = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    a_n    = a_r;
    bx_n   = bx_r;
    c_n    = c_r;
    cnt_n  = cnt;
    s_n    = S;
    co_n   = Co;
    v_n    = V;
    done_n = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
          a_n   = A;
          bx_n  = sub ? ~B : B;
          c_n   = sub;
          cnt_n = '0;
          s_n   = '0;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < int'(NIBBLES); i++) begin
          if (cnt == CW'(i)) s_n[4*i +: 4] = slice_s;
        end
        c_n   = slice_co;
        cnt_n = cnt + CW'(1);
        if (cnt == LAST) begin
          co_n   = slice_co;
          // Overflow: both effective operands share a sign the result lacks.
          v_n    = (a_r[W-1] == bx_r[W-1]) & (slice_s[3] != a_r[W-1]);
          done_n = 1'b1;
        end
      end
      default: ;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      bx_r <= '0;
      c_r  <= 1'b0;
      cnt  <= '0;
      S    <= '0;
      Co   <= 1'b0;
      V    <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      a_r  <= a_n;
      bx_r <= bx_n;
      c_r  <= c_n;
      cnt  <= cnt_n;
      S    <= s_n;
      Co   <= co_n;
      V    <= v_n;
      busy <= busy_n;
      done <= done_n;
    end
  end

endmodule
